// File: rtl/dog_mode_ctrl_pkg.sv
// Shared definitions for the toy-dog control stage and its display consumer:
// FSM state encodings, code widths and the action-code step helper.
package dog_mode_ctrl_pkg;

  localparam int ACT_W = 3;
  localparam int SPD_W = 2;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACT  = 2'd2
  } state_t;

  localparam logic [ACT_W-1:0] ACT_IDLE = 3'd0;

  // Next action code: idle or the last action both lead to action 1.
  function automatic logic [ACT_W-1:0] next_act(input logic [ACT_W-1:0] cur,
                                                input int num);
    if (cur == ACT_IDLE || int'(cur) >= num) return ACT_W'(1);
    return cur + ACT_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  logic w_diff;
  logic w_accept;

  // A new level is accepted on the DEB_CYCLES-th consecutive differing sample.
  assign w_diff   = (r_sync2 != r_level);
  assign w_accept = w_diff && (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Synchronise, count consecutive differing samples, flag accepted rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_press <= w_accept && r_sync2;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/dog_mode_ctrl.sv
// Toy-dog control stage: debounced buttons drive the OFF/IDLE/ACTING FSM that
// produces the registered power, action and speed codes, plus the free-running
// digit-scan toggle for the display.
module dog_mode_ctrl
  import dog_mode_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int SCAN_DIV   = 25000,
  parameter int ACT_TICKS  = 100000000,
  parameter int NUM_ACT    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_onoff,
  input  logic             btn_act,
  input  logic             btn_spd,
  output logic             onoff,
  output logic [ACT_W-1:0] act_code,
  output logic [SPD_W-1:0] spd_code,
  output logic             scan_sel
);

  localparam int TMR_W = $clog2(ACT_TICKS);
  localparam int SCN_W = $clog2(SCAN_DIV);

  logic w_p_on;
  logic w_p_act;
  logic w_p_spd;

  state_t           r_state, w_state;
  logic             r_onoff, w_onoff;
  logic [ACT_W-1:0] r_act,   w_act;
  logic [SPD_W-1:0] r_spd,   w_spd;
  logic [TMR_W-1:0] r_tmr,   w_tmr;

  logic [SCN_W-1:0] r_scn_cnt;
  logic             r_scan;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_onoff (
    .clk(clk), .rst(rst), .btn_raw(btn_onoff), .press(w_p_on)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_act (
    .clk(clk), .rst(rst), .btn_raw(btn_act), .press(w_p_act)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_spd (
    .clk(clk), .rst(rst), .btn_raw(btn_spd), .press(w_p_spd)
  );

  // FSM and output code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_onoff <= 1'b0;
      r_act   <= ACT_IDLE;
      r_spd   <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state;
      r_onoff <= w_onoff;
      r_act   <= w_act;
      r_spd   <= w_spd;
      r_tmr   <= w_tmr;
    end
  end

  // Next state: power press dominates; act reload beats timer expiry.
  always_comb begin
    w_state = r_state;
    w_onoff = r_onoff;
    w_act   = r_act;
    w_spd   = r_spd;
    w_tmr   = r_tmr;
    case (r_state)
      ST_IDLE, ST_ACT: begin
        if (w_p_on) begin
          w_state = ST_OFF;
          w_onoff = 1'b0;
          w_act   = ACT_IDLE;
          w_spd   = '0;
          w_tmr   = '0;
        end else begin
          if (r_state == ST_ACT && r_tmr != '0) w_tmr = r_tmr - TMR_W'(1);
          if (w_p_spd) w_spd = r_spd + SPD_W'(1);
          if (w_p_act) begin
            w_state = ST_ACT;
            w_act   = next_act(r_act, NUM_ACT);
            w_tmr   = TMR_W'(ACT_TICKS - 1);
          end else if (r_state == ST_ACT && r_tmr == '0) begin
            w_state = ST_IDLE;
            w_act   = ACT_IDLE;
          end
        end
      end
      default: begin
        if (w_p_on) begin
          w_state = ST_IDLE;
          w_onoff = 1'b1;
          w_act   = ACT_IDLE;
          w_spd   = '0;
        end
      end
    endcase
  end

  // Free-running scan divider; runs in every state so the display always scans.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scn_cnt <= '0;
      r_scan    <= 1'b0;
    end else if (r_scn_cnt == SCN_W'(SCAN_DIV - 1)) begin
      r_scn_cnt <= '0;
      r_scan    <= ~r_scan;
    end else begin
      r_scn_cnt <= r_scn_cnt + SCN_W'(1);
    end
  end

  assign onoff    = r_onoff;
  assign act_code = r_act;
  assign spd_code = r_spd;
  assign scan_sel = r_scan;

endmodule

// File: tb/tb_dog_mode_ctrl.sv
// Bench for dog_mode_ctrl: directed sequences, a vector table and random
// button activity, all checked against a cycle-level behavioural model.
module tb_dog_mode_ctrl;

  localparam int DEB   = 4;
  localparam int DIV   = 4;
  localparam int TICKS = 20;
  localparam int NUM   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_on = 1'b0, b_act = 1'b0, b_spd = 1'b0;
  logic       onoff;
  logic [2:0] act_code;
  logic [1:0] spd_code;
  logic       scan_sel;

  int checks   = 0;
  int failures = 0;
  int shown    = 0;

  dog_mode_ctrl #(
    .DEB_CYCLES(DEB), .SCAN_DIV(DIV), .ACT_TICKS(TICKS), .NUM_ACT(NUM)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_onoff(b_on), .btn_act(b_act), .btn_spd(b_spd),
    .onoff(onoff), .act_code(act_code), .spd_code(spd_code), .scan_sel(scan_sel)
  );

  always #5 clk = ~clk;

  // Behavioural model: delayed raw samples, run-length acceptance, and an
  // FSM that tracks the action end as an absolute cycle number.
  bit     m_d0[3], m_d1[3], m_lvl[3], m_pend[3];
  int     m_run[3];
  bit     m_on;
  int     m_act, m_spd, m_n;
  longint m_cyc = 0, m_end = 0;

  always @(posedge clk) begin : model
    bit raw[3];
    bit p[3];
    bit s;
    raw[0] = b_on; raw[1] = b_act; raw[2] = b_spd;
    m_cyc++;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_d0[b] = 0; m_d1[b] = 0; m_lvl[b] = 0; m_pend[b] = 0; m_run[b] = 0;
      end
      m_on = 0; m_act = 0; m_spd = 0; m_n = 0;
    end else begin
      for (int b = 0; b < 3; b++) p[b] = m_pend[b];
      if (!m_on) begin
        if (p[0]) begin m_on = 1; m_act = 0; m_spd = 0; end
      end else if (p[0]) begin
        m_on = 0; m_act = 0; m_spd = 0;
      end else begin
        if (p[2]) m_spd = (m_spd + 1) % 4;
        if (p[1]) begin
          m_act = (m_act % NUM) + 1;
          m_end = m_cyc + TICKS;
        end else if (m_act != 0 && m_cyc == m_end) begin
          m_act = 0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_pend[b] = 0;
        s = m_d1[b];
        if (s == m_lvl[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = s; m_run[b] = 0; m_pend[b] = s;
          end
        end
        m_d1[b] = m_d0[b];
        m_d0[b] = raw[b];
      end
      m_n++;
    end
  end

  // Every cycle, outputs must agree with the model.
  always @(negedge clk) begin : model_cmp
    logic [6:0] got, exp;
    got = {onoff, act_code, spd_code, scan_sel};
    exp = {m_on, 3'(m_act), 2'(m_spd), 1'((m_n / DIV) % 2)};
    checks++;
    if (got !== exp) begin
      failures++;
      if (shown < 20)
        $display("FAIL model_cmp t=%0t got on/act/spd/scan=%b exp=%b", $time, got, exp);
      shown++;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic o, input int a, input int s);
    chk(nm, {onoff, act_code, spd_code}, {1'b0, o, 3'(a), 2'(s)});
  endtask

  typedef struct {
    logic on, act, spd;
    int   hold;
    logic exp_on;
    int   exp_act, exp_spd;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{0,0,0, 3, 0,0,0};
    vt[1]  = '{1,0,0,10, 1,0,0};
    vt[2]  = '{0,0,0, 8, 1,0,0};
    vt[3]  = '{0,0,1, 8, 1,0,1};
    vt[4]  = '{0,0,0, 8, 1,0,1};
    vt[5]  = '{0,0,1, 8, 1,0,2};
    vt[6]  = '{0,0,0, 8, 1,0,2};
    vt[7]  = '{0,1,0, 8, 1,1,2};
    vt[8]  = '{0,0,0, 6, 1,1,2};
    vt[9]  = '{0,0,0,20, 1,0,2};
    vt[10] = '{1,0,0, 8, 0,0,0};
    vt[11] = '{0,0,0, 8, 0,0,0};
    vt[12] = '{0,1,0, 8, 0,0,0};
    vt[13] = '{0,0,0, 8, 0,0,0};

    // Reset and idle scan
    @(negedge clk);
    ticks(3);
    chk_all("reset_outputs", 0, 0, 0);
    chk("reset_scan", scan_sel, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_scan", scan_sel, ((i + 1) / DIV) % 2);
    end
    chk_all("idle_outputs", 0, 0, 0);

    // Power-on latency, single pulse on hold, glitch rejection
    b_on = 1'b1;
    ticks(6);
    chk("on_before_latency", onoff, 0);
    tick();
    chk("on_at_latency", onoff, 1);
    ticks(3);
    b_on = 1'b0;
    ticks(8);
    chk("on_hold_once", onoff, 1);
    b_on = 1'b1;
    ticks(2);
    b_on = 1'b0;
    ticks(12);
    chk("on_glitch", onoff, 1);

    // Single action lasts exactly TICKS cycles
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(1);
    chk("act_before", act_code, 0);
    tick();
    chk("act_start", act_code, 1);
    ticks(TICKS - 1);
    chk("act_last", act_code, 1);
    tick();
    chk("act_expire", act_code, 0);

    // Re-press at cycle 10 advances the code and restarts the timer
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(2);
    chk("act2_start", act_code, 1);
    ticks(3);
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(1);
    chk("act2_pre", act_code, 1);
    tick();
    chk("act2_adv", act_code, 2);
    ticks(TICKS - 1);
    chk("act2_last", act_code, 2);
    tick();
    chk("act2_expire", act_code, 0);

    // Action wrap and speed wrap
    for (int k = 0; k < 6; k++) begin
      b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(2);
      chk("act_seq", act_code, (k % NUM) + 1);
      ticks(3);
    end
    for (int k = 0; k < 5; k++) begin
      b_spd = 1'b1; ticks(5); b_spd = 1'b0; ticks(2);
      chk("spd_seq", spd_code, (k + 1) % 4);
      ticks(3);
    end

    // Power and speed together while acting: power wins, speed lost
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(2);
    chk_all("acting_pre_off", 1, 1, 1);
    b_on = 1'b1; b_spd = 1'b1; ticks(5); b_on = 1'b0; b_spd = 1'b0; ticks(1);
    chk_all("simul_before", 1, 1, 1);
    tick();
    chk_all("simul_off", 0, 0, 0);
    ticks(8);
    chk_all("simul_spd_lost", 0, 0, 0);

    // Reset in mid-action
    b_on = 1'b1; ticks(5); b_on = 1'b0; ticks(5);
    for (int k = 0; k < 2; k++) begin
      b_spd = 1'b1; ticks(5); b_spd = 1'b0; ticks(5);
    end
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(2);
    chk_all("pre_rst", 1, 1, 2);
    rst = 1'b1;
    tick();
    chk_all("mid_rst", 0, 0, 0);
    rst = 1'b0;
    b_act = 1'b1; ticks(5); b_act = 1'b0; ticks(8);
    chk_all("act_ignored_off", 0, 0, 0);

    // Vector table
    for (int v = 0; v < 14; v++) begin
      b_on = vt[v].on; b_act = vt[v].act; b_spd = vt[v].spd;
      ticks(vt[v].hold);
      chk($sformatf("vec%0d", v), {onoff, act_code, spd_code},
          {1'b0, vt[v].exp_on, 3'(vt[v].exp_act), 2'(vt[v].exp_spd)});
    end
    b_on = 1'b0; b_act = 1'b0; b_spd = 1'b0;

    // Random activity against the model
    for (int s = 0; s < 400; s++) begin
      b_on  = ($urandom_range(0, 5) == 0);
      b_act = ($urandom_range(0, 2) == 0);
      b_spd = ($urandom_range(0, 2) == 0);
      ticks($urandom_range(1, 12));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        ticks($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    b_on = 1'b0; b_act = 1'b0; b_spd = 1'b0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
